// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns and converter FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg7_pkg;

    // Double-dabble converter states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } dabble_state_e;

    // Active-high segment patterns, bit6..0 = g..a.
    localparam logic [6:0] SEG_PATTERN [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Map a BCD nibble to its pattern; non-decimal nibbles show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nib <= 4'd9) begin
            pat = SEG_PATTERN[nib];
        end
        return pat;
    endfunction

endpackage

// File: rtl/bcd_dabble16.sv
// Iterative 16-bit binary to 4-digit BCD converter (shift-and-add-3), flags values above 9999.
// Latency: start edge to done = 17 cycles for a convertible value, 1 cycle for an out-of-range value.
// Backpressure: start is only honoured while busy_o is low; done_o is a single-cycle strobe.
module bcd_dabble16
    import seg7_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        dash_o,
    output logic [15:0] bcd_o
);

    dabble_state_e state_q, state_d;
    logic [15:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          dash_q, dash_d;
    logic [15:0]   adj;
    logic [3:0]    nib;

    // Add-3 correction of every BCD nibble that would overflow past 9 when doubled.
    always_comb begin
        adj = bcd_q;
        nib = 4'd0;
        for (int i = 0; i < 4; i++) begin
            nib = bcd_q[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // Next-state logic: load, iterate MSB-first for 16 cycles, then present the result for one cycle.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dash_d  = dash_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (bin_i > 16'd9999) begin
                        dash_d  = 1'b1;
                        state_d = COMMIT;
                    end else begin
                        dash_d  = 1'b0;
                        bin_d   = bin_i;
                        bcd_d   = 16'd0;
                        cnt_d   = 4'd15;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_d = {adj[14:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Converter state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            bin_q   <= 16'd0;
            bcd_q   <= 16'd0;
            cnt_q   <= 4'd0;
            dash_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dash_q  <= dash_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == COMMIT);
    assign dash_o = dash_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-segment driver: accepts a binary value, converts to BCD, scans digits with dead time.
// Latency: accept edge to new digits committed = 17 cycles (1 for an overflow value); outputs registered.
// Backpressure: load_ready is low while a conversion is in flight; load_valid without ready is dropped.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_CYCLES   = 16000,
    parameter int DEAD_CYCLES   = 16,
    parameter int BLANK_LEADING = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] value,
    input  logic [3:0]  dots,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        overflow,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_en
);

    localparam int              CW       = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_DEAD = CW'(DEAD_CYCLES);

    logic          rdy_q;
    logic          conv_busy;
    logic          conv_done;
    logic          conv_dash;
    logic [15:0]   conv_bcd;
    logic          start;

    logic [15:0]   digits_q;
    logic          dash_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    slot_q;
    logic [7:0]    seg_n_q, seg_n_d;
    logic [3:0]    dig_en_q, dig_en_d;

    logic [3:0]    cur_nib;
    logic          lead_blank;
    logic [6:0]    seg_on;

    // rdy_q keeps load_ready low during reset and until the first edge after release.
    assign load_ready = rdy_q & ~conv_busy;
    assign start      = load_valid & load_ready;

    bcd_dabble16 u_dabble (
        .CLK     (CLK),
        .RST     (RST),
        .start_i (start),
        .bin_i   (value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .dash_o  (conv_dash),
        .bcd_o   (conv_bcd)
    );

    // Ready gate and atomic commit of the displayed digits and dash/overflow flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_q    <= 1'b0;
            digits_q <= 16'd0;
            dash_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (conv_done) begin
                dash_q <= conv_dash;
                if (!conv_dash) begin
                    digits_q <= conv_bcd;
                end
            end
        end
    end

    // Slot timer: count out one digit slot, then step to the next less-significant digit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            slot_q <= 2'd3;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            slot_q <= slot_q - 2'd1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Segment/enable selection for the current slot; everything dark during dead time.
    always_comb begin
        seg_n_d    = 8'hFF;
        dig_en_d   = 4'b0000;
        cur_nib    = digits_q[{slot_q, 2'b00} +: 4];
        // A digit is a leading zero when it and all more-significant digits are zero.
        lead_blank = (BLANK_LEADING != 0) && (slot_q != 2'd0) &&
                     ((digits_q >> {slot_q, 2'b00}) == 16'd0);
        if (dash_q) begin
            seg_on = SEG_DASH;
        end else if (lead_blank) begin
            seg_on = SEG_BLANK;
        end else begin
            seg_on = seg_decode(cur_nib);
        end
        if (cnt_q >= CNT_DEAD) begin
            dig_en_d = 4'b0001 << slot_q;
            seg_n_d  = {~dots[slot_q], ~seg_on};
        end
    end

    // Register segments and enables together so they switch on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_n_q  <= 8'hFF;
            dig_en_q <= 4'b0000;
        end else begin
            seg_n_q  <= seg_n_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign seg_n    = seg_n_q;
    assign dig_en   = dig_en_q;
    assign overflow = dash_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a short scan period.
// Latency: n/a.
// Backpressure: loads wait for load_ready with a bounded cycle budget.
module tb_seg7_scan_driver;

    localparam int SCAN = 8;
    localparam int DEAD = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] value = 16'd0;
    logic [3:0]  dots = 4'd0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        overflow;
    logic [7:0]  seg_n;
    logic [3:0]  dig_en;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;   // rising edges since reset release
    int mval  = 0;   // value the display is expected to show

    seg7_scan_driver #(
        .SCAN_CYCLES   (SCAN),
        .DEAD_CYCLES   (DEAD),
        .BLANK_LEADING (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .value      (value),
        .dots       (dots),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .overflow   (overflow),
        .seg_n      (seg_n),
        .dig_en     (dig_en)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST) begin
        if (RST) cyc = 0;
        else     cyc = cyc + 1;
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected {dig_en, seg_n} for scan position c (cycles since reset) showing value v.
    function automatic logic [11:0] exp_scan(input int c, input int v, input logic [3:0] dt);
        int         slot;
        int         p10;
        logic [6:0] segs;
        logic [3:0] en;
        slot = 3 - ((c / SCAN) % 4);
        p10  = 1;
        for (int i = 0; i < slot; i++) p10 = p10 * 10;
        if ((c % SCAN) < DEAD) return {4'b0000, 8'hFF};
        if (v > 9999)                   segs = 7'h40;
        else if (slot != 0 && v < p10)  segs = 7'h00;
        else                            segs = pat((v / p10) % 10);
        en = 4'b0001 << slot;
        return {en, ~dt[slot], ~segs};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic scan_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check(tag, {20'd0, dig_en, seg_n}, {20'd0, exp_scan(cyc - 1, mval, dots)});
        end
    endtask

    // Present v until accepted, optionally keep load_valid high with junk values
    // for 'noise' cycles into the conversion, and check busy time and overflow.
    task automatic do_load(input logic [15:0] v, input int noise);
        int wait_n;
        int lo;
        wait_n = 0;
        while (load_ready !== 1'b1 && wait_n < 100) begin
            @(negedge CLK);
            wait_n++;
        end
        check("ready_before_load", {31'd0, load_ready}, 32'd1);
        value      = v;
        load_valid = 1'b1;
        @(negedge CLK);
        lo = 0;
        while (load_ready !== 1'b1 && lo < 40) begin
            lo++;
            if (lo <= noise) value = 16'($urandom);
            else             load_valid = 1'b0;
            @(negedge CLK);
        end
        load_valid = 1'b0;
        check("ready_low_cycles", lo, (v > 16'd9999) ? 32'd1 : 32'd17);
        check("overflow", {31'd0, overflow}, {31'd0, (v > 16'd9999)});
        mval = int'(v);
    endtask

    initial begin
        logic [15:0] rv;
        int          nz;

        // Reset state
        #1 RST = 1'b1;
        #1;
        check("rst_seg_n", {24'd0, seg_n}, 32'hFF);
        check("rst_dig_en", {28'd0, dig_en}, 32'h0);
        check("rst_ready", {31'd0, load_ready}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge CLK);
        check("rst_ready_held", {31'd0, load_ready}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_release", {31'd0, load_ready}, 32'd1);
        scan_check(40, "idle_zero");

        // Directed loads
        dots = 4'b0100;
        do_load(16'd1234, 0);
        scan_check(32, "v1234_dots");
        dots = 4'b0000;
        do_load(16'd9999, 0);
        scan_check(32, "v9999");
        do_load(16'd0, 0);
        scan_check(32, "v0");
        do_load(16'd10, 0);
        scan_check(32, "v10");
        do_load(16'd10000, 0);
        scan_check(32, "dash");
        do_load(16'd42, 0);
        scan_check(32, "v42");
        do_load(16'd65535, 0);
        scan_check(16, "dash_max");
        dots = 4'b1001;
        do_load(16'd5678, 12);
        scan_check(32, "noise_hold");

        // Randomized loads
        for (int k = 0; k < 14; k++) begin
            dots = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       rv = 16'($urandom);
                1:       rv = 16'($urandom_range(0, 99));
                default: rv = 16'($urandom_range(0, 9999));
            endcase
            nz = (rv > 16'd9999) ? 0 : $urandom_range(0, 15);
            do_load(rv, nz);
            scan_check(32, "random");
        end

        // Reset in the middle of a conversion
        dots = 4'b0000;
        do_load(16'd777, 0);
        value      = 16'd4321;
        load_valid = 1'b1;
        @(negedge CLK);
        load_valid = 1'b0;
        repeat (7) @(negedge CLK);
        check("midconv_busy", {31'd0, load_ready}, 32'd0);
        RST = 1'b1;
        #1;
        check("midrst_seg_n", {24'd0, seg_n}, 32'hFF);
        check("midrst_dig_en", {28'd0, dig_en}, 32'h0);
        check("midrst_ready", {31'd0, load_ready}, 32'd0);
        @(negedge CLK);
        RST  = 1'b0;
        mval = 0;
        @(negedge CLK);
        check("midrst_ready_back", {31'd0, load_ready}, 32'd1);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        scan_check(32, "after_midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
